// File: rtl/tap_pkg.sv
// Shared types for the TAP result-channel arbiter: controller states and the
// message id carried by the closing summary record.
package tap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_SUMMARY,
        ST_DONE
    } state_t;

    localparam int SUMMARY_MSG_ID = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant wins.
// The pointer register lives in the parent so it only moves on real transfers.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tap_report_arbiter.sv
// Shares one TAP result channel between NUM_REQ requesters: numbers results,
// keeps pass/fail totals and closes the run with a single summary record.
module tap_report_arbiter
    import tap_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MSG_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_pass,
    input  logic [NUM_REQ*MSG_W-1:0]   req_msg_id,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       finish_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           out_idx,
    output logic                       out_pass,
    output logic [MSG_W-1:0]           out_msg_id,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    output logic                       out_last,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic                       overflow,
    output logic                       done
);

    localparam int               SRC_W   = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [SRC_W-1:0]   last_grant;
    logic [SRC_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win;
    logic               fin_flag;
    logic [CNT_W-1:0]   idx_cnt;
    logic               sel_pass;
    logic [MSG_W-1:0]   sel_msg;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(SRC_W)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .en         (state == ST_IDLE),
        .grant      (win),
        .grant_idx  (win_idx)
    );

    // Grant is only ever raised on a valid line, so any grant is a transfer.
    assign req_ready = win;
    assign sel_pass  = |(win & req_pass);

    always_comb begin
        sel_msg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) sel_msg = req_msg_id[i*MSG_W +: MSG_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= SRC_W'(NUM_REQ - 1);
            fin_flag   <= 1'b0;
            idx_cnt    <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_pass   <= 1'b0;
            out_msg_id <= '0;
            out_src    <= '0;
            out_last   <= 1'b0;
        end else begin
            if (finish_req && state != ST_DONE) fin_flag <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (|win) begin
                        out_valid  <= 1'b1;
                        out_idx    <= sat_inc(idx_cnt);
                        out_pass   <= sel_pass;
                        out_msg_id <= sel_msg;
                        out_src    <= win_idx;
                        out_last   <= 1'b0;
                        last_grant <= win_idx;
                        state      <= ST_EMIT;
                    end else if (fin_flag) begin
                        out_valid  <= 1'b1;
                        out_idx    <= idx_cnt;
                        out_pass   <= (fail_cnt == '0);
                        out_msg_id <= MSG_W'(SUMMARY_MSG_ID);
                        out_src    <= '0;
                        out_last   <= 1'b1;
                        state      <= ST_SUMMARY;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx_cnt   <= sat_inc(idx_cnt);
                        // pass/fail totals never exceed the index, so it alone flags saturation
                        if (idx_cnt == CNT_MAX) overflow <= 1'b1;
                        if (out_pass) pass_cnt <= sat_inc(pass_cnt);
                        else          fail_cnt <= sat_inc(fail_cnt);
                        state     <= ST_IDLE;
                    end
                end
                ST_SUMMARY: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tap_report_arbiter.md
# tap_report_arbiter

Synthesizable scheduler that shares one Test Anything Protocol (TAP) result channel between several self-checking requesters in a hardware test harness. It round-robin arbitrates pass/fail results, numbers them with TAP test indices starting at 1, and keeps running pass/fail totals. On a finish request it drains outstanding work and emits one summary record, giving the downstream log formatter a "1..N" plan count and overall verdict.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- MSG_W, 8, width of message identifier selecting a result string downstream
- CNT_W, 16, width of test index and counters

- clk  in  1  sole clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a result pending
- req_pass  in  NUM_REQ  result of requester i (1 = ok, 0 = not ok)
- req_msg_id  in  NUM_REQ*MSG_W  message id of requester i, slice i at [i*MSG_W +: MSG_W]
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
- finish_req  in  1  single-cycle or level request to close the test run
- out_valid  out  1  record available
- out_ready  in  1  downstream accepts record
- out_idx  out  CNT_W  TAP index of record, or total count on summary
- out_pass  out  1  record verdict; on summary, 1 iff fail_cnt == 0
- out_msg_id  out  MSG_W  message id; 0 on summary
- out_src  out  $clog2(NUM_REQ)  granted requester; 0 on summary
- out_last  out  1  1 only on the summary record
- pass_cnt  out  CNT_W  accepted passing results
- fail_cnt  out  CNT_W  accepted failing results
- overflow  out  1  sticky: index counter saturated
- done  out  1  summary accepted; run closed

## Operation
- States: IDLE, EMIT, SUMMARY, DONE.
- IDLE: if any req_valid, req_ready asserted combinationally for the round-robin winner; on transfer capture pass/msg_id/src, index = idx_cnt+1, go EMIT. Else if finish latched, go SUMMARY.
- Round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins first.
- EMIT: out_valid=1, fields stable until out_ready; on out_valid && out_ready update idx_cnt, pass_cnt or fail_cnt, return IDLE.
- finish_req latched into a sticky flag in any state before DONE; pending requests still granted before summary (requests win over finish in the same cycle).
- SUMMARY: out_valid=1, out_last=1, out_idx=idx_cnt, out_pass=(fail_cnt==0); on out_ready go DONE.
- DONE: req_ready=0, out_valid=0, done=1 until reset; all counters hold.
- Counters saturate at 2^CNT_W-1; increment attempted at saturation sets overflow, record still emitted with saturated index.
- req_ready never asserted outside IDLE; requester dropping req_valid without transfer is legal, no state effect.

## Timing
- Reset values: req_ready=0 (combinational, gated by state), out_valid=0, out_idx=0, out_pass=0, out_msg_id=0, out_src=0, out_last=0, pass_cnt=0, fail_cnt=0, overflow=0, done=0, state IDLE, finish flag 0.
- Grant-to-out_valid latency: 1 cycle. Max throughput: one record per 2 cycles with out_ready tied high.
- Counters update in the cycle after out handshake; visible with next record.
- Reset mid-EMIT/SUMMARY: record dropped, everything returns to reset values immediately.

## Structure
- Package tap_pkg: state enum, summary-msg-id constant (0), clog2 helper if needed.
- Sub-module rr_arbiter (NUM_REQ): request vector, last_grant, enable -> one-hot grant and encoded index; purely combinational, pointer register kept in parent.

## Test plan
- Reset then req_valid=4'b0001, pass=1, msg 0x11, out_ready=1 -> record idx 1, pass 1, src 0, msg 0x11; pass_cnt=1.
- All four valid continuously, out_ready=1 -> src order 0,1,2,3,0; idx 1..5; grant every 2nd cycle.
- out_ready low 5 cycles during EMIT -> out fields stable, no req_ready, no counter change; single record on release.
- finish_req same cycle as req_valid[2] (pass=0) -> record idx 1 not ok emitted first, then summary idx 1, out_pass 0, out_last 1; done=1, req_ready stays 0.
- CNT_W=2, 4 passing results -> idx 1,2,3,3, overflow=1 after fourth; summary out_idx 3.
- rst_n low during EMIT -> out_valid 0 same cycle, counters 0, next grant goes to requester 0.
